instruction_sequencer: RTL

//  Multi-cycle fetch/decode/execute controller sitting directly upstream of the 8x4 register file.

---
 rtl/seq_pkg.sv | 38 +++
 rtl/seq_alu.sv | 31 +++
 rtl/instruction_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, FSM states,
// instruction field positions and the PC width helper.
package seq_pkg;

  localparam int INSTR_OP_MSB  = 11;
  localparam int INSTR_OP_LSB  = 9;
  localparam int INSTR_RD_MSB  = 8;
  localparam int INSTR_RD_LSB  = 6;
  localparam int INSTR_RS1_MSB = 5;
  localparam int INSTR_RS1_LSB = 3;
  localparam int INSTR_RS2_MSB = 2;
  localparam int INSTR_RS2_LSB = 0;
  localparam int INSTR_IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_LOADI = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_MOV   = 3'd5,
    OP_BEQZ  = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READ  = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

  // A single-word memory still needs a 1-bit address.
  function automatic int pcWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: computes the write-back value for each opcode
// and flags whether operand a is zero (used by BEQZ).
module seq_alu
  import seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_LOADI: result_o = imm_i;
      OP_ADD:   result_o = a_i + b_i;
      OP_SUB:   result_o = a_i - b_i;
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_MOV:   result_o = a_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (a_i == '0);

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/read/execute controller driving the 8x4 register file; one instruction every
// three cycles, with external register loads accepted only while idle.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int IMEM_DEPTH = 8,
  parameter int INSTR_W    = 12,
  parameter int DATA_W     = 4,
  parameter int RADDR_W    = 3,
  localparam int PC_W      = pcWidth(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ext_load_en,
  input  logic [RADDR_W-1:0] ext_load_addr,
  input  logic [DATA_W-1:0]  ext_load_data,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [RADDR_W-1:0] RF_ad1,
  output logic [RADDR_W-1:0] RF_ad2,
  input  logic [DATA_W-1:0]  RF_d1,
  input  logic [DATA_W-1:0]  RF_d2,
  output logic [RADDR_W-1:0] RF_wa,
  output logic [DATA_W-1:0]  RF_wd,
  output logic               RF_we,
  output logic               RF_external_load,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               done_q, done_d;

  opcode_e            irOp;
  logic [RADDR_W-1:0] irRd, irRs1, irRs2;
  logic [DATA_W-1:0]  irImm;
  logic [DATA_W-1:0]  aluResult;
  logic               aluZero;
  logic [PC_W-1:0]    pcNext;

  assign irOp  = opcode_e'(ir_q[INSTR_OP_MSB:INSTR_OP_LSB]);
  assign irRd  = ir_q[INSTR_RD_MSB:INSTR_RD_LSB];
  assign irRs1 = ir_q[INSTR_RS1_MSB:INSTR_RS1_LSB];
  assign irRs2 = ir_q[INSTR_RS2_MSB:INSTR_RS2_LSB];
  assign irImm = ir_q[INSTR_IMM_LSB +: DATA_W];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (irOp),
    .a_i     (RF_d1),
    .b_i     (RF_d2),
    .imm_i   (irImm),
    .result_o(aluResult),
    .zero_o  (aluZero)
  );

  assign pcNext = (pc_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    done_d           = 1'b0;
    RF_ad1           = '0;
    RF_ad2           = '0;
    RF_wa            = '0;
    RF_wd            = '0;
    RF_we            = 1'b0;
    RF_external_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The reset term keeps the external load path quiet while reset is held.
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end else if (ext_load_en && reset) begin
          RF_external_load = 1'b1;
          RF_wa            = ext_load_addr;
          RF_wd            = ext_load_data;
        end
      end
      ST_FETCH: begin
        ir_d    = imem_rdata;
        state_d = ST_READ;
      end
      ST_READ: begin
        RF_ad1  = irRs1;
        RF_ad2  = irRs2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        RF_wa = irRd;
        RF_wd = aluResult;
        RF_we = (irOp != OP_BEQZ) && (irOp != OP_HALT);
        pc_d  = (irOp == OP_BEQZ && aluZero) ? PC_W'(irRd) : pcNext;
        if (irOp == OP_HALT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;

endmodule
